// File: rtl/matrix_pkg.sv
// Shared keycodes, FSM state type and dimension limit for matrix entry.
package matrix_pkg;

    localparam int unsigned MAX_DIM = 4;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_BKSP  = 4'hB;
    localparam logic [3:0] KEY_CLR   = 4'hC;
    localparam logic [3:0] KEY_NEG   = 4'hE;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        COMMIT,
        HANDOFF
    } entry_state_t;

endpackage

// File: rtl/dec_accum.sv
// Decimal digit accumulator with saturation and backspace.
// MATRIX_ENTRY_NEG_EN adds a sign flag and a two's-complement output.
module dec_accum #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned MAX_DIGITS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic              back,
    input  logic              clear,
    input  logic              neg_toggle,
    input  logic              neg_start,
    input  logic [3:0]        digit,
    output logic [DATA_W-1:0] value
);

    localparam int unsigned CNT_W  = $clog2(MAX_DIGITS + 1);
    localparam int unsigned PROD_W = DATA_W + 4;
`ifdef MATRIX_ENTRY_NEG_EN
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
`else
    localparam logic [DATA_W-1:0] SAT_MAX = {DATA_W{1'b1}};
`endif

    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PROD_W-1:0] prod;
    logic              neg_q, neg_d;

    always_comb begin
        prod  = PROD_W'(acc_q) * PROD_W'(10) + PROD_W'(digit);
        acc_d = acc_q;
        cnt_d = cnt_q;
        neg_d = neg_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
            neg_d = 1'b0;
        end else if (load) begin
            acc_d = (PROD_W'(digit) > PROD_W'(SAT_MAX)) ? SAT_MAX : DATA_W'(digit);
            cnt_d = CNT_W'(1);
            neg_d = 1'b0;
        end else if (shift) begin
            // Digits beyond MAX_DIGITS are dropped silently.
            if (cnt_q < CNT_W'(MAX_DIGITS)) begin
                acc_d = (prod > PROD_W'(SAT_MAX)) ? SAT_MAX : prod[DATA_W-1:0];
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (back) begin
            if (cnt_q != '0) begin
                acc_d = acc_q / DATA_W'(10);
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (neg_start) begin
            acc_d = '0;
            cnt_d = '0;
            neg_d = 1'b1;
        end else if (neg_toggle) begin
            neg_d = ~neg_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            neg_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            neg_q <= neg_d;
        end
    end

`ifdef MATRIX_ENTRY_NEG_EN
    assign value = neg_q ? (DATA_W'(0) - acc_q) : acc_q;
`else
    logic unused_neg;
    assign unused_neg = neg_toggle ^ neg_start ^ neg_q;
    assign value      = acc_q;
`endif

endmodule

// File: rtl/matrix_entry_ctrl.sv
// Keypad-driven row-major entry of a ROWS x COLS matrix with valid/ready handoff.
// Optional signed entry via MATRIX_ENTRY_NEG_EN.
module matrix_entry_ctrl
    import matrix_pkg::*;
#(
    parameter int unsigned ROWS       = 2,
    parameter int unsigned COLS       = 2,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned MAX_DIGITS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              keystrobe,
    input  logic [3:0]        keycode,
    output logic              wr_en,
    output logic [1:0]        wr_row,
    output logic [1:0]        wr_col,
    output logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] entry_val,
    output logic [1:0]        cur_row,
    output logic [1:0]        cur_col,
    output logic              mat_valid,
    input  logic              mat_ready,
    output logic              busy
);

    entry_state_t state_q, state_d;
    logic [1:0]   row_q, row_d, col_q, col_d;
    logic         acc_load, acc_shift, acc_back, acc_clear, neg_toggle, neg_start;
    logic         key_digit, key_enter, key_bksp, key_clr, last_elem;
    logic [DATA_W-1:0] acc_value;

    assign key_digit = keystrobe && (keycode < 4'd10);
    assign key_enter = keystrobe && (keycode == KEY_ENTER);
    assign key_bksp  = keystrobe && (keycode == KEY_BKSP);
    assign key_clr   = keystrobe && (keycode == KEY_CLR);
    assign last_elem = (row_q == 2'(ROWS - 1)) && (col_q == 2'(COLS - 1));

    dec_accum #(
        .DATA_W     (DATA_W),
        .MAX_DIGITS (MAX_DIGITS)
    ) u_dec_accum (
        .clk        (clk),
        .rst        (rst),
        .load       (acc_load),
        .shift      (acc_shift),
        .back       (acc_back),
        .clear      (acc_clear),
        .neg_toggle (neg_toggle),
        .neg_start  (neg_start),
        .digit      (keycode),
        .value      (acc_value)
    );

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        acc_load   = 1'b0;
        acc_shift  = 1'b0;
        acc_back   = 1'b0;
        acc_clear  = 1'b0;
        neg_toggle = 1'b0;
        neg_start  = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_digit) begin
                    acc_load = 1'b1;
                    state_d  = ENTRY;
                end else if (key_enter) begin
                    state_d = COMMIT;
`ifdef MATRIX_ENTRY_NEG_EN
                end else if (keystrobe && (keycode == KEY_NEG)) begin
                    neg_start = 1'b1;
                    state_d   = ENTRY;
`endif
                end
            end
            ENTRY: begin
                if (key_clr) begin
                    acc_clear = 1'b1;
                    row_d     = '0;
                    col_d     = '0;
                    state_d   = IDLE;
                end else if (key_digit) begin
                    acc_shift = 1'b1;
                end else if (key_bksp) begin
                    acc_back = 1'b1;
                end else if (key_enter) begin
                    state_d = COMMIT;
`ifdef MATRIX_ENTRY_NEG_EN
                end else if (keystrobe && (keycode == KEY_NEG)) begin
                    neg_toggle = 1'b1;
`endif
                end
            end
            COMMIT: begin
                acc_clear = 1'b1;
                // A CLEAR_ALL landing on the commit cycle suppresses the write.
                if (key_clr) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = IDLE;
                end else begin
                    wr_en = 1'b1;
                    if (col_q == 2'(COLS - 1)) begin
                        col_d = '0;
                        row_d = last_elem ? 2'd0 : row_q + 2'd1;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                    state_d = last_elem ? HANDOFF : ENTRY;
                end
            end
            HANDOFF: begin
                if (mat_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    assign wr_row    = wr_en ? row_q : 2'd0;
    assign wr_col    = wr_en ? col_q : 2'd0;
    assign wr_data   = wr_en ? acc_value : '0;
    assign entry_val = acc_value;
    assign cur_row   = row_q;
    assign cur_col   = col_q;
    assign mat_valid = (state_q == HANDOFF);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_matrix_entry_ctrl.sv
// Directed bench for matrix_entry_ctrl; element writes are checked against a scoreboard queue.
module tb_matrix_entry_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       keystrobe;
    logic [3:0] keycode;
    logic       wr_en;
    logic [1:0] wr_row, wr_col, cur_row, cur_col;
    logic [7:0] wr_data, entry_val;
    logic       mat_valid, mat_ready, busy;

    int checks = 0;
    int errors = 0;
    int pushes = 0;
    int writes = 0;

    typedef struct {
        logic [1:0] r;
        logic [1:0] c;
        logic [7:0] d;
    } wr_t;
    wr_t exp_q[$];

    matrix_entry_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .keystrobe (keystrobe),
        .keycode   (keycode),
        .wr_en     (wr_en),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data),
        .entry_val (entry_val),
        .cur_row   (cur_row),
        .cur_col   (cur_col),
        .mat_valid (mat_valid),
        .mat_ready (mat_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        keystrobe = 1'b1;
        keycode   = k;
        @(negedge clk);
        keystrobe = 1'b0;
        keycode   = 4'h0;
    endtask

    task automatic expect_wr(input logic [1:0] r, input logic [1:0] c, input logic [7:0] d);
        wr_t e;
        e.r = r;
        e.c = c;
        e.d = d;
        exp_q.push_back(e);
        pushes++;
    endtask

    // Scoreboard: every write strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            writes++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(wr_en), 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_row", 32'(wr_row), 32'(e.r));
                check("wr_col", 32'(wr_col), 32'(e.c));
                check("wr_data", 32'(wr_data), 32'(e.d));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        keystrobe = 1'b0;
        keycode   = 4'h0;
        mat_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_mat_valid", 32'(mat_valid), 0);
        check("rst_entry_val", 32'(entry_val), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_pos", {30'd0, cur_row} * 4 + 32'(cur_col), 0);
        rst = 1'b0;
        @(negedge clk);

        // Full 2x2 matrix: 12, 3, 45, 6
        press(4'd1);
        check("ev_1", 32'(entry_val), 1);
        check("busy_entry", 32'(busy), 1);
        press(4'd2);
        check("ev_12", 32'(entry_val), 12);
        expect_wr(2'd0, 2'd0, 8'd12);
        press(4'hA);
        press(4'd3);
        check("pos_01_col", 32'(cur_col), 1);
        check("ev_3", 32'(entry_val), 3);
        expect_wr(2'd0, 2'd1, 8'd3);
        press(4'hA);
        press(4'd4);
        press(4'd5);
        check("pos_10_row", 32'(cur_row), 1);
        check("ev_45", 32'(entry_val), 45);
        expect_wr(2'd1, 2'd0, 8'd45);
        press(4'hA);
        press(4'd6);
        expect_wr(2'd1, 2'd1, 8'd6);
        press(4'hA);
        check("mat_valid_lat1", 32'(mat_valid), 0);
        @(negedge clk);
        check("mat_valid_lat2", 32'(mat_valid), 1);

        // Stall handoff for 5 cycles; keys (incl. CLEAR_ALL) must be ignored.
        for (int i = 0; i < 5; i++) begin
            check("mat_valid_hold", 32'(mat_valid), 1);
            keystrobe = (i == 1) || (i == 3);
            keycode   = (i == 1) ? 4'd7 : 4'hC;
            @(negedge clk);
        end
        keystrobe = 1'b0;
        check("mat_valid_hold_end", 32'(mat_valid), 1);
        mat_ready = 1'b1;
        @(negedge clk);
        mat_ready = 1'b0;
        check("mat_valid_drop", 32'(mat_valid), 0);
        check("busy_after_xfer", 32'(busy), 0);
        check("pos_after_xfer", {30'd0, cur_row} * 4 + 32'(cur_col), 0);

        // Saturation and digit limit
        press(4'd9);
        check("sat_9", 32'(entry_val), 9);
        press(4'd9);
        check("sat_99", 32'(entry_val), 99);
        press(4'd9);
        check("sat_999", 32'(entry_val), 255);
        press(4'd9);
        check("sat_4th_ignored", 32'(entry_val), 255);
        expect_wr(2'd0, 2'd0, 8'd255);
        press(4'hA);

        // Backspace down past empty
        press(4'd4);
        check("bk_4", 32'(entry_val), 4);
        press(4'd7);
        check("bk_47", 32'(entry_val), 47);
        press(4'hB);
        check("bk_back1", 32'(entry_val), 4);
        press(4'hB);
        check("bk_back2", 32'(entry_val), 0);
        press(4'hB);
        check("bk_back3", 32'(entry_val), 0);
        check("bk_still_entry", 32'(busy), 1);
        press(4'd2);
        check("bk_2", 32'(entry_val), 2);
        expect_wr(2'd0, 2'd1, 8'd2);
        press(4'hA);

        // CLEAR_ALL after two elements, then reset mid-entry
        press(4'd8);
        check("pos_before_clr", 32'(cur_row), 1);
        press(4'hC);
        check("clr_busy", 32'(busy), 0);
        check("clr_pos", {30'd0, cur_row} * 4 + 32'(cur_col), 0);
        check("clr_ev", 32'(entry_val), 0);
        press(4'd3);
        check("re_entry", 32'(busy), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_ev", 32'(entry_val), 0);
        check("rst_mid_pos", {30'd0, cur_row} * 4 + 32'(cur_col), 0);
        expect_wr(2'd0, 2'd0, 8'd0);
        press(4'hA);
        @(negedge clk);
        check("idle_enter_pos", 32'(cur_col), 1);
        press(4'hC);
        check("clr2_busy", 32'(busy), 0);

`ifdef MATRIX_ENTRY_NEG_EN
        press(4'hE);
        check("neg_start_busy", 32'(busy), 1);
        check("neg_start_ev", 32'(entry_val), 0);
        press(4'd5);
        check("neg_ev", 32'(entry_val), 32'hFB);
        expect_wr(2'd0, 2'd0, 8'hFB);
        press(4'hA);
        press(4'd2);
        press(4'd0);
        check("neg_sat_20", 32'(entry_val), 20);
        press(4'd0);
        check("neg_sat_127", 32'(entry_val), 127);
        expect_wr(2'd0, 2'd1, 8'd127);
        press(4'hA);
        press(4'hC);
`else
        press(4'hE);
        check("neg_ignored_idle", 32'(busy), 0);
        press(4'hD);
        check("d_ignored_idle", 32'(busy), 0);
        press(4'd3);
        press(4'hD);
        check("d_ignored_entry", 32'(entry_val), 3);
        press(4'hE);
        check("e_ignored_entry", 32'(entry_val), 3);
        press(4'hF);
        check("f_ignored_entry", 32'(entry_val), 3);
        check("f_pos", 32'(cur_col), 0);
        press(4'hC);
`endif

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 0);
        check("write_count", 32'(writes), 32'(pushes));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_entry_ctrl.md
Name: matrix_entry_ctrl

Overview:
- Sequences keypad entry of one ROWS x COLS matrix, element by element, in row-major order.
- Consumes raw keypad strobes/codes: digits 0-9 accumulate a decimal value; command keys commit, correct or abort.
- Writes each committed element into the downstream matrix register file.
- Hands off the completed matrix to the operation unit via a valid/ready handshake.

Parameters:
- ROWS, 2, matrix row count (1-4)
- COLS, 2, matrix column count (1-4)
- DATA_W, 8, element width in bits
- MAX_DIGITS, 3, maximum decimal digits accepted per element

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- keystrobe  in  1  single-cycle pulse, keycode valid
- keycode  in  4  0-9 digit; 0xA ENTER; 0xB BACKSPACE; 0xC CLEAR_ALL; 0xE NEG (feature only); others ignored
- wr_en  out  1  one-cycle element write strobe
- wr_row  out  2  row of the element being written
- wr_col  out  2  column of the element being written
- wr_data  out  DATA_W  element value being written
- entry_val  out  DATA_W  current partial value, for display
- cur_row  out  2  element under entry
- cur_col  out  2  element under entry
- mat_valid  out  1  complete matrix available
- mat_ready  in  1  consumer accepts matrix
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: synchronous, takes priority over all other inputs and is honoured in every state. State returns to IDLE. The following are cleared to 0: all outputs, the accumulator and the digit count.
- States are IDLE, ENTRY, COMMIT and HANDOFF.
- IDLE:
  - A digit strobe loads acc=digit and cnt=1, then moves to ENTRY. cur_row and cur_col are 0.
  - ENTER in IDLE commits value 0 at (0,0) and moves to COMMIT.
  - Other keys are ignored.
- ENTRY, digit key:
  - If cnt<MAX_DIGITS: acc=acc*10+digit, cnt++.
  - Otherwise the key is ignored.
  - Accumulation saturates at 2^DATA_W-1. The intermediate product uses DATA_W+4 bits.
- ENTRY, BACKSPACE:
  - acc=acc/10, cnt--.
  - At cnt=0 the key is a no-op and the state stays ENTRY.
- ENTRY, ENTER: move to COMMIT.
- CLEAR_ALL, in ENTRY or COMMIT: acc, cnt and position are cleared and the state returns to IDLE. No write occurs.
- COMMIT (exactly one cycle):
  - wr_en=1, with wr_row/wr_col = current position and wr_data=acc.
  - Then acc and cnt are cleared and the position advances (col++; wrap to col 0 and row++).
  - After the last element (ROWS-1, COLS-1), move to HANDOFF. Otherwise move to ENTRY.
- HANDOFF:
  - mat_valid=1, held until a cycle with mat_ready=1. That cycle completes the transfer; the next state is IDLE and mat_valid deasserts.
  - Keystrobes are ignored, including CLEAR_ALL.
  - mat_ready outside HANDOFF is ignored.
- Latency:
  - Keystrobe to entry_val update: 1 cycle (registered).
  - ENTER to wr_en: 1 cycle.
  - Last ENTER to mat_valid: 2 cycles.
- Keystrobe arriving during the COMMIT cycle: only CLEAR_ALL acts; all others are dropped.
- Unassigned keycodes (0xD, 0xF, and 0xE without the feature) never change state.

Optional Feature:
- Macro: MATRIX_ENTRY_NEG_EN.
- When defined:
  - Key 0xE toggles a sign flag in ENTRY; in IDLE it starts ENTRY with acc=0 and the flag set.
  - wr_data is two's complement: -acc when the flag is set.
  - Magnitude saturates at 2^(DATA_W-1)-1.
  - The flag clears on COMMIT, CLEAR_ALL and reset.
  - entry_val shows the signed value.
- When not defined:
  - 0xE is ignored.
  - Values are unsigned with saturation at 2^DATA_W-1.

Decomposition:
- Package matrix_pkg holds:
  - keycode constants KEY_ENTER, KEY_BKSP, KEY_CLR, KEY_NEG
  - enum entry_state_t {IDLE, ENTRY, COMMIT, HANDOFF}
  - localparam for the maximum dimension (4)
- One sub-module, dec_accum, is natural. It contains the acc/cnt registers, the multiply-by-10 with saturation, the divide-by-10 backspace and the optional sign. It is controlled by load/shift/back/clear strobes from the FSM.

Test Plan:
- Enter key sequence 1,2,ENTER; 3,ENTER; 4,5,ENTER; 6,ENTER -> writes (0,0)=12, (0,1)=3, (1,0)=45, (1,1)=6, one wr_en each. mat_valid asserts 2 cycles after the final ENTER.
- Hold mat_ready=0 for 5 cycles, then 1 -> mat_valid is held all 5 cycles and drops the cycle after the transfer. Keystrobes sent during HANDOFF produce no writes.
- Enter digits 9,9,9,9 then ENTER (DATA_W=8, MAX_DIGITS=3) -> the 4th digit is ignored; wr_data=255 (999 saturated).
- Enter 4,7,BKSP,BKSP,BKSP,2,ENTER -> entry_val steps 4, 47, 4, 0, 0, 2; wr_data=2.
- Issue CLEAR_ALL after 2 committed elements, then assert rst in the middle of ENTRY -> the state returns to IDLE and position resets to (0,0) with no write. The next ENTER writes (0,0).
- With MATRIX_ENTRY_NEG_EN defined, enter 0xE,5,ENTER -> wr_data=0xFB (-5). Enter 2,0,0,ENTER -> wr_data=127.
